// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: major opcodes, the canonical NOP and the immediate formats.
// Also holds the operand-usage helpers used by hazard detection.
package riscv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP || opcode == STORE || opcode == BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies the opcode into an immediate format
// and produces the sign-extended immediate (0 for OP and unknown opcodes).
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_fmt_e    fmt
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      LOAD, OP_IMM, JALR: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH:             fmt = FMT_B;
      LUI, AUIPC:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      default:            fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: owns the register-file read port, holds one instruction for execute,
// inserts a load-use bubble, flushes on redirect and bypasses same-edge writeback collisions.
module id_issue_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [DATA_WIDTH-1:0]    if_instr,
  input  logic [DATA_WIDTH-1:0]    if_pc,
  output logic [ADDRESS_WIDTH-1:0] rf_ad1,
  output logic [ADDRESS_WIDTH-1:0] rf_ad2,
  input  logic [DATA_WIDTH-1:0]    rf_rd1,
  input  logic [DATA_WIDTH-1:0]    rf_rd2,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  input  logic                     ex_stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_instr,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_rs1_val,
  output logic [DATA_WIDTH-1:0]    ex_rs2_val,
  output logic [DATA_WIDTH-1:0]    ex_imm
);

  logic [6:0]               if_op, ex_op;
  logic [ADDRESS_WIDTH-1:0] if_rs1, if_rs2, ex_rs1, ex_rs2;
  logic                     hold, advance, accept, load_use;
  logic                     wr_hit1, wr_hit2;
  logic                     hit1, hit2;
  logic [DATA_WIDTH-1:0]    shadow1, shadow2;
  imm_fmt_e                 ex_fmt;

  assign if_op  = if_instr[6:0];
  assign if_rs1 = if_instr[19:15];
  assign if_rs2 = if_instr[24:20];
  assign ex_op  = ex_instr[6:0];
  assign ex_rs1 = ex_instr[19:15];
  assign ex_rs2 = ex_instr[24:20];

  imm_gen u_imm_gen (
    .instr (ex_instr),
    .imm   (ex_imm),
    .fmt   (ex_fmt)
  );

  assign ex_rd = (ex_fmt == FMT_S || ex_fmt == FMT_B) ? '0 : ex_instr[11:7];

  assign load_use = ex_valid && (ex_op == LOAD) && (ex_rd != '0) && if_valid &&
                    ((uses_rs1(if_op) && if_rs1 == ex_rd) ||
                     (uses_rs2(if_op) && if_rs2 == ex_rd));

  // A flush always lets the stage advance, even under an execute stall.
  assign hold     = ex_valid && ex_stall && !flush;
  assign advance  = !hold;
  assign if_ready = !flush && !load_use && (!ex_valid || !ex_stall);
  assign accept   = if_valid && if_ready;

  // While holding, the file keeps re-reading the held sources so late writes are picked up.
  assign rf_ad1 = advance ? if_rs1 : ex_rs1;
  assign rf_ad2 = advance ? if_rs2 : ex_rs2;

  assign wr_hit1 = wb_we && (wb_rd != '0) && (wb_rd == rf_ad1);
  assign wr_hit2 = wb_we && (wb_rd != '0) && (wb_rd == rf_ad2);

  // NOTE: sequential state is assigned with non-blocking (<=) only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_instr <= NOP_INSTR;
      ex_pc    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_instr <= if_instr;
      ex_pc    <= if_pc;
    end else if (advance) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else if (flush) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      if (wr_hit1)      hit1 <= 1'b1;
      else if (advance) hit1 <= 1'b0;
      if (wr_hit2)      hit2 <= 1'b1;
      else if (advance) hit2 <= 1'b0;
    end
  end

  // NOTE: shadow data is qualified by hit1/hit2, so it needs no reset and lives in a reset-free block.
  always_ff @(posedge clk) begin
    if (wr_hit1) shadow1 <= wb_data;
    if (wr_hit2) shadow2 <= wb_data;
  end

  assign ex_rs1_val = (ex_rs1 == '0) ? '0 : (hit1 ? shadow1 : rf_rd1);
  assign ex_rs2_val = (ex_rs2 == '0) ? '0 : (hit2 ? shadow2 : rf_rd2);

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage with a behavioural register file that cannot
// resolve same-edge write/read collisions (read returns the old value).
module tb_id_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_ad1, rf_ad2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_instr;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] ADD_X6_X5_X5  = 32'h0052_8333;
  localparam logic [31:0] ADDI_X7_X5_1  = 32'h0012_8393;
  localparam logic [31:0] LUI_X10       = 32'h1234_5537;
  localparam logic [31:0] LW_X8_X1      = 32'h0000_A403;
  localparam logic [31:0] ADD_X9_X8_X2  = 32'h0024_04B3;
  localparam logic [31:0] ADD_X9_X3_X2  = 32'h0021_84B3;
  localparam logic [31:0] SW_X2_M4_X1   = 32'hFE20_AE23;
  localparam logic [31:0] ADD_X11_X0_X0 = 32'h0000_05B3;

  id_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .rf_ad1     (rf_ad1),
    .rf_ad2     (rf_ad2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_instr   (ex_instr),
    .ex_rd      (ex_rd),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_imm     (ex_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read of the pre-write contents; x0 is not hardwired here.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    rf_rd1 <= regs[rf_ad1];
    rf_rd2 <= regs[rf_ad2];
    if (wb_we) regs[wb_rd] <= wb_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
  endtask

  initial begin
    rst_n    = 1'b0;
    ex_stall = 1'b0;
    flush    = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);

    // Preload the file while the stage is in reset.
    wb(1'b1, 5'd1, 32'd100); tick();
    wb(1'b1, 5'd2, 32'd20);  tick();
    wb(1'b1, 5'd3, 32'd30);  tick();
    wb(1'b1, 5'd5, 32'd7);   tick();
    wb(1'b1, 5'd8, 32'h88);  tick();
    wb(1'b1, 5'd0, 32'h0);   tick();
    wb(1'b0, 5'd0, 32'h0);

    check("reset_valid", {31'b0, ex_valid}, 32'd0);
    check("reset_instr", ex_instr, 32'h0000_0013);
    check("reset_pc",    ex_pc,    32'h0);
    check("reset_rd",    {27'b0, ex_rd}, 32'h0);

    rst_n = 1'b1;

    // add x6,x5,x5 with x5=7
    drive(1'b1, ADD_X6_X5_X5, 32'h100);
    #1;
    check("add_ready", {31'b0, if_ready}, 32'd1);
    check("add_ad1",   {27'b0, rf_ad1}, 32'd5);
    tick();
    check("add_valid", {31'b0, ex_valid}, 32'd1);
    check("add_rs1",   ex_rs1_val, 32'd7);
    check("add_rs2",   ex_rs2_val, 32'd7);
    check("add_pc",    ex_pc, 32'h100);
    check("add_rd",    {27'b0, ex_rd}, 32'd6);
    check("add_imm",   ex_imm, 32'h0);

    // addi x7,x5,1 with x5<=9 on its accept edge
    drive(1'b1, ADDI_X7_X5_1, 32'h104);
    wb(1'b1, 5'd5, 32'd9);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    check("coll_rs1", ex_rs1_val, 32'd9);
    check("coll_imm", ex_imm, 32'd1);
    check("coll_rd",  {27'b0, ex_rd}, 32'd7);

    // Three-cycle hold with writes to x5 during the hold
    ex_stall = 1'b1;
    drive(1'b1, LUI_X10, 32'h108);
    wb(1'b1, 5'd5, 32'd11);
    #1;
    check("hold_ready", {31'b0, if_ready}, 32'd0);
    check("hold_ad1",   {27'b0, rf_ad1}, 32'd5);
    tick();
    check("hold1_rs1", ex_rs1_val, 32'd11);
    check("hold1_pc",  ex_pc, 32'h104);
    wb(1'b1, 5'd5, 32'd12);
    tick();
    check("hold2_rs1", ex_rs1_val, 32'd12);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("hold3_rs1",   ex_rs1_val, 32'd12);
    check("hold3_instr", ex_instr, ADDI_X7_X5_1);
    check("hold3_valid", {31'b0, ex_valid}, 32'd1);
    ex_stall = 1'b0;
    #1;
    check("rel_ready", {31'b0, if_ready}, 32'd1);
    check("rel_rs1",   ex_rs1_val, 32'd12);
    tick();
    check("lui_instr", ex_instr, LUI_X10);
    check("lui_imm",   ex_imm, 32'h1234_5000);
    check("lui_rd",    {27'b0, ex_rd}, 32'd10);

    // Load-use: one bubble
    drive(1'b1, LW_X8_X1, 32'h10C);
    tick();
    check("lw_instr", ex_instr, LW_X8_X1);
    drive(1'b1, ADD_X9_X8_X2, 32'h110);
    #1;
    check("lu_ready", {31'b0, if_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'b0, ex_valid}, 32'd0);
    check("lu_ready2", {31'b0, if_ready}, 32'd1);
    tick();
    check("lu_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_pc",    ex_pc, 32'h110);
    check("lu_rs1",   ex_rs1_val, 32'h88);
    check("lu_rs2",   ex_rs2_val, 32'd20);

    // Independent add after lw: no bubble
    drive(1'b1, LW_X8_X1, 32'h114);
    tick();
    drive(1'b1, ADD_X9_X3_X2, 32'h118);
    #1;
    check("nolu_ready", {31'b0, if_ready}, 32'd1);
    tick();
    check("nolu_pc",  ex_pc, 32'h118);
    check("nolu_rs1", ex_rs1_val, 32'd30);

    // Store: S immediate, rd forced 0
    drive(1'b1, SW_X2_M4_X1, 32'h11C);
    tick();
    check("sw_imm", ex_imm, 32'hFFFF_FFFC);
    check("sw_rd",  {27'b0, ex_rd}, 32'd0);
    check("sw_rs1", ex_rs1_val, 32'd100);
    check("sw_rs2", ex_rs2_val, 32'd20);

    // Flush beats stall and accept
    ex_stall = 1'b1;
    flush    = 1'b1;
    drive(1'b1, ADD_X11_X0_X0, 32'h120);
    #1;
    check("flush_ready", {31'b0, if_ready}, 32'd0);
    tick();
    check("flush_valid", {31'b0, ex_valid}, 32'd0);
    flush    = 1'b0;
    ex_stall = 1'b0;

    // x0 reads stay 0 even when wb writes rd=0
    drive(1'b1, ADD_X11_X0_X0, 32'h124);
    wb(1'b1, 5'd0, 32'hDEAD);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    check("x0_valid", {31'b0, ex_valid}, 32'd1);
    check("x0_pc",    ex_pc, 32'h124);
    check("x0_rs1",   ex_rs1_val, 32'h0);
    check("x0_rs2",   ex_rs2_val, 32'h0);
    drive(1'b1, ADD_X11_X0_X0, 32'h128);
    tick();
    check("x0b_rs1", ex_rs1_val, 32'h0);
    check("x0b_rs2", ex_rs2_val, 32'h0);

    // Reset mid-run
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'b0, ex_valid}, 32'd0);
    check("mrst_instr", ex_instr, 32'h0000_0013);
    check("mrst_pc",    ex_pc, 32'h0);
    drive(1'b1, ADD_X6_X5_X5, 32'h200);
    tick();
    check("mrst_noacc", {31'b0, ex_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst_acc_valid", {31'b0, ex_valid}, 32'd1);
    check("mrst_acc_pc",    ex_pc, 32'h200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
